// File: rtl/fetch_unit_pkg.sv
// ============================================================================
//  Module   : fetch_unit_pkg
//  Brief    : Shared pipeline definitions: fetch-state encoding, data width
//             and default reset PC / bubble instruction values.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF     = 32'h0000_0000;
   localparam logic [XLEN-1:0] BUBBLE_INSTR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2
   } fetch_state_e;

endpackage : fetch_unit_pkg

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction-fetch stage. Owns PCF, issues one request at a time
//             over a req/ready + rvalid handshake, holds the returned
//             instruction for IF/ID, honours StallF and EX redirects and
//             discards responses made stale by a redirect.
//             Optional macro FETCH_MISALIGN_CHK_EN: word-align redirect
//             targets and flag misaligned redirects on a sticky MisalignF.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEF,
   parameter logic [XLEN-1:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            StallF,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] InstrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F,
   output logic            FetchValidF,
   output logic            FetchBusyF,
   output logic            MisalignF
);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pcf_q;
   logic [XLEN-1:0] instr_q;
   logic            valid_q;
   // Set when the outstanding response belongs to a PC that has since been
   // redirected away from; that response must be thrown away on arrival.
   logic            drop_q;

   // PC loaded on a redirect (aligned when the misalignment check is built in).
   logic [XLEN-1:0] redirect_pc_d;

`ifdef FETCH_MISALIGN_CHK_EN
   logic            misalign_q;
   logic            target_misaligned;

   assign target_misaligned = (PCTargetE[1:0] != 2'b00);
   assign redirect_pc_d     = {PCTargetE[XLEN-1:2], 2'b00};
   assign MisalignF         = misalign_q;

   // Sticky misalignment flag: any redirect to a non-word address sets it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else if (PCSrcE && target_misaligned) begin
         misalign_q <= 1'b1;
      end
   end
`else
   assign redirect_pc_d = PCTargetE;
   assign MisalignF     = 1'b0;
`endif

   assign imem_req    = (state_q == S_ISSUE);
   assign imem_addr   = pcf_q;
   assign PCF         = pcf_q;
   assign PCPlus4F    = pcf_q + 32'd4;
   assign InstrF      = instr_q;
   assign FetchValidF = valid_q;
   assign FetchBusyF  = (state_q == S_ISSUE) || (state_q == S_WAIT);

   // Fetch FSM: issue -> wait for response -> hold instruction until consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_ISSUE;
         pcf_q   <= RESET_PC;
         instr_q <= BUBBLE_INSTR;
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         case (state_q)
            S_ISSUE: begin
               // A redirect may retarget an unaccepted request; if the
               // request is accepted in the same cycle its response is stale.
               if (PCSrcE) begin
                  pcf_q <= redirect_pc_d;
               end
               if (imem_ready) begin
                  state_q <= S_WAIT;
                  drop_q  <= PCSrcE;
               end
            end

            S_WAIT: begin
               if (imem_rvalid) begin
                  if (drop_q || PCSrcE) begin
                     drop_q  <= 1'b0;
                     state_q <= S_ISSUE;
                     if (PCSrcE) begin
                        pcf_q <= redirect_pc_d;
                     end
                  end else begin
                     instr_q <= imem_rdata;
                     valid_q <= 1'b1;
                     state_q <= S_VALID;
                  end
               end else if (PCSrcE) begin
                  // Last redirect wins; response still in flight is stale.
                  pcf_q  <= redirect_pc_d;
                  drop_q <= 1'b1;
               end
            end

            S_VALID: begin
               if (PCSrcE) begin
                  pcf_q   <= redirect_pc_d;
                  valid_q <= 1'b0;
                  instr_q <= BUBBLE_INSTR;
                  state_q <= S_ISSUE;
               end else if (!StallF) begin
                  // IF/ID captures the instruction on this edge.
                  pcf_q   <= pcf_q + 32'd4;
                  valid_q <= 1'b0;
                  instr_q <= BUBBLE_INSTR;
                  state_q <= S_ISSUE;
               end
            end

            default: begin
               state_q <= S_ISSUE;
               valid_q <= 1'b0;
               instr_q <= BUBBLE_INSTR;
               drop_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Self-checking bench for fetch_unit: a cycle table for the
//             streaming / stall / ready-backpressure flow, plus hand-written
//             sequences for redirect, stale-response, reset and wrap cases.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] BUB    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        StallF;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        FetchValidF;
   logic        FetchBusyF;
   logic        MisalignF;

   int errors = 0;
   int checks = 0;

   fetch_unit #(
      .RESET_PC     (RST_PC),
      .BUBBLE_INSTR (BUB)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .StallF      (StallF),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .InstrF      (InstrF),
      .PCF         (PCF),
      .PCPlus4F    (PCPlus4F),
      .FetchValidF (FetchValidF),
      .FetchBusyF  (FetchBusyF),
      .MisalignF   (MisalignF)
   );

   always #5 clk = ~clk;

   // Memory contents: a recognisable word per address.
   function automatic logic [31:0] word(input logic [31:0] a);
      return 32'h5A5A_0000 | {16'h0000, a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Auto memory model: 1-cycle response latency after acceptance.
   logic        auto_mem = 1'b0;
   logic        pend     = 1'b0;
   logic [31:0] pend_addr;

   task automatic tick();
      logic        acc;
      logic [31:0] a;
      acc = imem_req & imem_ready;
      a   = imem_addr;
      @(posedge clk);
      #1;
      if (auto_mem) begin
         imem_rvalid = 1'b0;
         if (pend) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(pend_addr);
            pend        = 1'b0;
         end
         if (acc) begin
            pend      = 1'b1;
            pend_addr = a;
         end
         if (pend) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word(pend_addr);
            pend        = 1'b0;
         end
      end
   endtask

   typedef struct {
      logic        stall;
      logic        pcsrc;
      logic [31:0] tgt;
      logic        ready;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_instr;
      logic        e_req;
      logic        e_busy;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic st, input logic ps, input logic [31:0] tg, input logic rd,
                      input logic [31:0] pc, input logic vl, input logic [31:0] ins,
                      input logic rq, input logic bz);
      vec_t v;
      v.stall = st; v.pcsrc = ps; v.tgt = tg; v.ready = rd;
      v.e_pc = pc; v.e_valid = vl; v.e_instr = ins; v.e_req = rq; v.e_busy = bz;
      vq.push_back(v);
   endtask

   initial begin
      reset       = 1'b1;
      StallF      = 1'b0;
      PCSrcE      = 1'b0;
      PCTargetE   = 32'h0;
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      pend_addr   = 32'h0;

      // ---------------- reset state ----------------
      #2;
      chk("rst_pc",     PCF, RST_PC);
      chk("rst_req",    32'(imem_req), 32'd1);
      chk("rst_addr",   imem_addr, RST_PC);
      chk("rst_pc4",    PCPlus4F, RST_PC + 32'd4);
      chk("rst_valid",  32'(FetchValidF), 32'd0);
      chk("rst_instr",  InstrF, BUB);
      chk("rst_mis",    32'(MisalignF), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // ---------------- table: stream, stall, redirect+stall, backpressure ----
      //   stall pcsrc tgt        ready | pc        valid instr             req busy
      add(0, 0, 32'h0,   1,   32'h0,   0, BUB,              1, 1); // 0
      add(0, 0, 32'h0,   1,   32'h0,   0, BUB,              0, 1);
      add(0, 0, 32'h0,   1,   32'h0,   1, word(32'h0),      0, 0);
      add(0, 0, 32'h0,   1,   32'h4,   0, BUB,              1, 1); // 3
      add(0, 0, 32'h0,   1,   32'h4,   0, BUB,              0, 1);
      add(0, 0, 32'h0,   1,   32'h4,   1, word(32'h4),      0, 0);
      add(0, 0, 32'h0,   1,   32'h8,   0, BUB,              1, 1); // 6
      add(0, 0, 32'h0,   1,   32'h8,   0, BUB,              0, 1);
      add(1, 0, 32'h0,   1,   32'h8,   1, word(32'h8),      0, 0); // stall x4
      add(1, 0, 32'h0,   1,   32'h8,   1, word(32'h8),      0, 0);
      add(1, 0, 32'h0,   1,   32'h8,   1, word(32'h8),      0, 0);
      add(1, 0, 32'h0,   1,   32'h8,   1, word(32'h8),      0, 0);
      add(0, 0, 32'h0,   1,   32'h8,   1, word(32'h8),      0, 0); // release
      add(0, 0, 32'h0,   1,   32'hC,   0, BUB,              1, 1);
      add(0, 0, 32'h0,   1,   32'hC,   0, BUB,              0, 1);
      add(1, 1, 32'h200, 1,   32'hC,   1, word(32'hC),      0, 0); // redirect beats stall
      add(0, 0, 32'h0,   0,   32'h200, 0, BUB,              1, 1); // ready low x5
      add(0, 0, 32'h0,   0,   32'h200, 0, BUB,              1, 1);
      add(0, 0, 32'h0,   0,   32'h200, 0, BUB,              1, 1);
      add(0, 0, 32'h0,   0,   32'h200, 0, BUB,              1, 1);
      add(0, 0, 32'h0,   0,   32'h200, 0, BUB,              1, 1);
      add(0, 0, 32'h0,   1,   32'h200, 0, BUB,              1, 1);
      add(0, 0, 32'h0,   1,   32'h200, 0, BUB,              0, 1);
      add(0, 0, 32'h0,   0,   32'h200, 1, word(32'h200),    0, 0);

      auto_mem = 1'b1;
      for (int i = 0; i < vq.size(); i++) begin
         StallF     = vq[i].stall;
         PCSrcE     = vq[i].pcsrc;
         PCTargetE  = vq[i].tgt;
         imem_ready = vq[i].ready;
         chk($sformatf("v%0d_pc", i),    PCF, vq[i].e_pc);
         chk($sformatf("v%0d_addr", i),  imem_addr, vq[i].e_pc);
         chk($sformatf("v%0d_pc4", i),   PCPlus4F, vq[i].e_pc + 32'd4);
         chk($sformatf("v%0d_valid", i), 32'(FetchValidF), 32'(vq[i].e_valid));
         chk($sformatf("v%0d_instr", i), InstrF, vq[i].e_instr);
         chk($sformatf("v%0d_req", i),   32'(imem_req), 32'(vq[i].e_req));
         chk($sformatf("v%0d_busy", i),  32'(FetchBusyF), 32'(vq[i].e_busy));
         tick();
      end
      auto_mem    = 1'b0;
      pend        = 1'b0;
      imem_rvalid = 1'b0;
      StallF      = 1'b0;
      PCSrcE      = 1'b0;
      imem_ready  = 1'b0;

      // ---------------- redirect in S_WAIT, late response dropped ----------
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      imem_ready = 1'b1;
      tick();                               // accepted -> S_WAIT
      imem_ready = 1'b0;
      PCSrcE = 1'b1; PCTargetE = 32'h100;
      chk("a_wait_busy", 32'(FetchBusyF), 32'd1);
      chk("a_wait_req",  32'(imem_req), 32'd0);
      tick();
      PCSrcE = 1'b0;
      chk("a_redir_pc",  PCF, 32'h100);
      chk("a_still_wait", 32'(imem_req), 32'd0);
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      tick();
      imem_rvalid = 1'b0;
      chk("a_drop_valid", 32'(FetchValidF), 32'd0);
      chk("a_drop_instr", InstrF, BUB);
      chk("a_reissue_req", 32'(imem_req), 32'd1);
      chk("a_reissue_addr", imem_addr, 32'h100);

      // repeated redirects while waiting: last target wins
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      PCSrcE = 1'b1; PCTargetE = 32'h300;
      tick();
      PCTargetE = 32'h400;
      tick();
      PCSrcE = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1;
      tick();
      imem_rvalid = 1'b0;
      chk("b_last_pc",  PCF, 32'h400);
      chk("b_valid",    32'(FetchValidF), 32'd0);
      chk("b_req",      32'(imem_req), 32'd1);

      // redirect coincident with acceptance: that response is stale
      imem_ready = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h500;
      tick();
      imem_ready = 1'b0; PCSrcE = 1'b0;
      chk("c_pc",      PCF, 32'h500);
      chk("c_waiting", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD2_BAD2;
      tick();
      imem_rvalid = 1'b0;
      chk("c_valid", 32'(FetchValidF), 32'd0);
      chk("c_addr",  imem_addr, 32'h500);
      chk("c_req",   32'(imem_req), 32'd1);

      // response and redirect in the same cycle: redirect wins
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD3_BAD3;
      PCSrcE = 1'b1; PCTargetE = 32'h600;
      tick();
      imem_rvalid = 1'b0; PCSrcE = 1'b0;
      chk("d_pc",    PCF, 32'h600);
      chk("d_valid", 32'(FetchValidF), 32'd0);
      chk("d_req",   32'(imem_req), 32'd1);

      // normal capture afterwards
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_rvalid = 1'b0;
      chk("e_valid", 32'(FetchValidF), 32'd1);
      chk("e_instr", InstrF, 32'h1234_5678);
      chk("e_pc",    PCF, 32'h600);

      // ---------------- reset mid-S_WAIT, stale response ignored ----------
      tick();                               // consumed -> PC 0x604
      chk("f_pc_inc", PCF, 32'h604);
      imem_ready = 1'b1;
      tick();                               // S_WAIT
      imem_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("f_async_pc",  PCF, RST_PC);
      chk("f_async_req", 32'(imem_req), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD4_BAD4;
      tick();
      imem_rvalid = 1'b0;
      chk("f_stale_valid", 32'(FetchValidF), 32'd0);
      chk("f_stale_instr", InstrF, BUB);
      chk("f_stale_pc",    PCF, RST_PC);
      chk("f_stale_req",   32'(imem_req), 32'd1);

      // ---------------- PC wrap at 2^32 ----------------
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
      tick();
      PCSrcE = 1'b0;
      chk("g_pc",  PCF, 32'hFFFF_FFFC);
      chk("g_pc4", PCPlus4F, 32'h0000_0000);
      auto_mem = 1'b1; imem_ready = 1'b1;
      tick();
      tick();
      chk("g_valid", 32'(FetchValidF), 32'd1);
      chk("g_instr", InstrF, word(32'hFFFF_FFFC));
      imem_ready = 1'b0;
      tick();
      auto_mem = 1'b0; pend = 1'b0; imem_rvalid = 1'b0;
      chk("g_wrap_pc", PCF, 32'h0);

      // ---------------- misaligned redirect ----------------
      PCSrcE = 1'b1; PCTargetE = 32'h102;
      tick();
      PCSrcE = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      chk("h_pc",  PCF, 32'h100);
      chk("h_mis", 32'(MisalignF), 32'd1);
`else
      chk("h_pc",  PCF, 32'h102);
      chk("h_mis", 32'(MisalignF), 32'd0);
`endif
      PCSrcE = 1'b1; PCTargetE = 32'h200;
      tick();
      PCSrcE = 1'b0;
      chk("h_pc2", PCF, 32'h200);
`ifdef FETCH_MISALIGN_CHK_EN
      chk("h_mis_sticky", 32'(MisalignF), 32'd1);
`else
      chk("h_mis_sticky", 32'(MisalignF), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_unit

`default_nettype wire
